// File: rtl/entry_rx_fsm_if.sv
// Byte handshake between the UART receiver and the keycode parser.
// master = receiver side, slave = parser side.
interface entry_rx_fsm_if;
   logic       rxready;
   logic [7:0] rxdata;
   logic       rdrxdata;

   modport master (output rxready, output rxdata, input  rdrxdata);
   modport slave  (input  rxready, input  rxdata, output rdrxdata);
endinterface

// File: rtl/entry_rx_fsm.sv
// Receive-side keycode parser: acknowledges each UART byte, assembles a packed
// BCD keycode from ASCII digits with backspace editing, and reports on CR.
module entry_rx_fsm #(
   parameter int MAXDIGITS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   entry_rx_fsm_if.slave          rx,
   output logic [4*MAXDIGITS-1:0] code,
   output logic                   code_valid,
   output logic                   code_error,
   output logic [3:0]             digit_count
);
   localparam int         W    = 4*MAXDIGITS;
   localparam logic [3:0] MAXC = 4'(MAXDIGITS);
   localparam logic [7:0] BS   = 8'h08;
   localparam logic [7:0] LF   = 8'h0A;
   localparam logic [7:0] CR   = 8'h0D;

   typedef enum logic [1:0] {IDLE, ACK, DECODE} state_t;

   state_t       state, state_nx;
   logic [7:0]   byte_r, byte_nx;
   logic [W-1:0] shift_r, shift_nx, code_nx, shift_app;
   logic [3:0]   count_nx;
   logic         bad_r, bad_nx;
   logic         rd_nx, valid_nx, error_nx;
   logic         is_digit;

   assign is_digit = (byte_r >= 8'h30) && (byte_r <= 8'h39);

   // New digit enters at the LS nibble so the first digit ends up most significant.
   generate
      if (MAXDIGITS > 1) begin : g_app_wide
         assign shift_app = {shift_r[W-5:0], byte_r[3:0]};
      end else begin : g_app_one
         assign shift_app = byte_r[3:0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         byte_r      <= '0;
         shift_r     <= '0;
         bad_r       <= 1'b0;
         code        <= '0;
         digit_count <= '0;
         rx.rdrxdata <= 1'b0;
         code_valid  <= 1'b0;
         code_error  <= 1'b0;
      end else begin
         state       <= state_nx;
         byte_r      <= byte_nx;
         shift_r     <= shift_nx;
         bad_r       <= bad_nx;
         code        <= code_nx;
         digit_count <= count_nx;
         rx.rdrxdata <= rd_nx;
         code_valid  <= valid_nx;
         code_error  <= error_nx;
      end
   end

   always_comb begin
      state_nx = state;
      byte_nx  = byte_r;
      shift_nx = shift_r;
      bad_nx   = bad_r;
      code_nx  = code;
      count_nx = digit_count;
      rd_nx    = 1'b0;
      valid_nx = 1'b0;
      error_nx = 1'b0;
      unique case (state)
         IDLE: begin
            if (rx.rxready) begin
               byte_nx  = rx.rxdata;
               rd_nx    = 1'b1;
               state_nx = ACK;
            end
         end
         // rxready is ignored here so the receiver has a cycle to drop it.
         ACK: state_nx = DECODE;
         DECODE: begin
            state_nx = IDLE;
            if (is_digit) begin
               if (digit_count == MAXC) begin
                  bad_nx = 1'b1;
               end else if (!bad_r) begin
                  shift_nx = shift_app;
                  count_nx = digit_count + 4'd1;
               end
            end else if (byte_r == BS) begin
               if (!bad_r && digit_count != 4'd0) begin
                  shift_nx = shift_r >> 4;
                  count_nx = digit_count - 4'd1;
               end
            end else if (byte_r == CR) begin
               if (!bad_r && digit_count == MAXC) begin
                  code_nx  = shift_r;
                  valid_nx = 1'b1;
               end else begin
                  error_nx = 1'b1;
               end
               shift_nx = '0;
               count_nx = '0;
               bad_nx   = 1'b0;
            end else if (byte_r != LF) begin
               bad_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: doc/entry_rx_fsm.md
# entry_rx_fsm

Receive-side entry parser for the UART path. It consumes bytes from the UART receiver through the ready/read-strobe handshake and assembles a fixed-length decimal keycode from ASCII digits, with backspace support. It reports a completed code or an error when a carriage return arrives. It sits between the UART receiver and the security controller, opposite the transmit-side message sequencers.

## Interface
- MAXDIGITS, 4: digits per keycode. Legal range 1..8.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rxready  in  1  UART receiver has an unread byte. Stays high until acknowledged.
- rxdata  in  8  received byte; valid while rxready=1.
- rdrxdata  out  1  one-cycle acknowledge strobe to the receiver; clears rxready.
- code  out  4*MAXDIGITS  last accepted keycode, packed BCD with the first digit in the MS nibble. Holds until the next accept.
- code_valid  out  1  one-cycle pulse when code is updated.
- code_error  out  1  one-cycle pulse when an entry is rejected.
- digit_count  out  4  digits currently buffered (0..MAXDIGITS).

## Operation
- Internal registers:
  - byte_r[7:0] holds the captured byte.
  - shift_r[4*MAXDIGITS-1:0] is the BCD assembly register.
  - bad_r is set once the current line is known bad.
- States:
  - IDLE: if rxready=1, then byte_r<=rxdata, rdrxdata<=1, go to ACK. Otherwise stay.
  - ACK: rdrxdata<=0, go to DECODE. rxready is not sampled here, which gives the receiver a cycle to drop it.
  - DECODE: classify byte_r, update state per the rules below, go to IDLE. rxready is not sampled here.
- DECODE rules:
  - Digit 0x30–0x39, bad_r=0, digit_count<MAXDIGITS: shift_r <= {shift_r[4*MAXDIGITS-5:0], byte_r[3:0]}, then digit_count+1.
  - Digit with digit_count=MAXDIGITS (overflow): bad_r<=1. shift_r and count are unchanged.
  - 0x08 (backspace), bad_r=0, digit_count>0: shift_r <= shift_r>>4, then digit_count-1.
  - 0x08 with digit_count=0: ignored.
  - 0x08 with bad_r=1: ignored; a bad line is not recoverable.
  - 0x0D (CR), bad_r=0, digit_count=MAXDIGITS: code<=shift_r, code_valid<=1.
  - 0x0D, any other case: code_error<=1 and code is unchanged.
  - After any CR: shift_r, digit_count and bad_r are all cleared.
  - 0x0A (LF): ignored, so CR-LF and CR are equivalent.
  - Any other byte: bad_r<=1.
- Every byte is acknowledged exactly once, including ignored and bad bytes.
- Reset values:
  - state=IDLE.
  - rdrxdata, code_valid, code_error = 0.
  - code, shift_r, byte_r, digit_count, bad_r = 0.
- Reset mid-entry discards the partial entry. No pulse is emitted.
- A reset asserted in the same cycle as a rdrxdata pulse drops the captured byte unprocessed.

## Timing
- Per byte, with rxready sampled high at edge N:
  - rdrxdata is high for the cycle after N, exactly one cycle.
  - DECODE occupies the cycle after N+1.
  - code_valid, code_error, code and digit_count update at edge N+2.
- Throughput is one byte per 3 clocks maximum. If rxready is held high, the next byte is captured at edge N+3.
- code_valid and code_error are never high in the same cycle. Each is high for exactly one cycle per CR.
- Receiver contract: rxready must be low by the cycle after rdrxdata. A still-high rxready in IDLE is treated as a new byte.

## Test plan
- Ready-held-high stream:
  - Stimulus: "1234\r" with MAXDIGITS=4, rxready held high with a new byte each acknowledge.
  - Response: 5 rdrxdata pulses spaced 3 clocks apart; code=0x1234; one code_valid pulse; digit_count returns to 0.
- Short entry and overflow:
  - Stimulus: "12\r", then "12345\r".
  - Response: two code_error pulses; code stays 0x1234; no code_valid.
- Backspace editing:
  - Stimulus: "129\x0834\r".
  - Response: digit_count sequence 1,2,3,2,3,4,0; code=0x1234; code_valid pulse.
  - Stimulus: "\x08\x081234\r".
  - Response: the leading backspaces are ignored; code=0x1234.
- Invalid byte poisons the line:
  - Stimulus: "12x4\r".
  - Response: code_error on the CR.
  - Stimulus: an immediate follow-up of "5678\r\n".
  - Response: code=0x5678, one code_valid; the LF is acknowledged with no pulse.
- Reset mid-entry:
  - Stimulus: "12", assert reset for 1 cycle, then "3456\r".
  - Response: all outputs are 0 after reset; code=0x3456 with a single code_valid.
- Slow sender:
  - Stimulus: gaps of 20 idle cycles between bytes of "9876\r".
  - Response: no rdrxdata pulse while rxready=0; code=0x9876.
